// File: rtl/tone_key_scheduler.sv
// Eight-key tone scheduler: picks the highest pressed key and drives one shared square-wave divider.
// Note changes and releases always let a high half-period run to completion.
module tone_key_scheduler #(
  parameter int DIV_SHIFT = 0,
  parameter int GAP_CYC   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic       enable,
  output logic       tone_out,
  output logic [2:0] note_idx,
  output logic       note_valid,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, RELEASE, GAP} state_t;

  state_t      state;
  logic [7:0]  key_q;
  logic [2:0]  winner;
  logic [15:0] half;
  logic [15:0] count;
  logic [31:0] gap_cnt;
  logic        pend;
  logic        terminal;

  function automatic logic [15:0] half_of(input logic [2:0] idx);
    logic [15:0] base;
    logic [15:0] sh;
    case (idx)
      3'd0:    base = 16'd47778;
      3'd1:    base = 16'd42566;
      3'd2:    base = 16'd37921;
      3'd3:    base = 16'd35793;
      3'd4:    base = 16'd31888;
      3'd5:    base = 16'd28409;
      3'd6:    base = 16'd25310;
      default: base = 16'd23889;
    endcase
    sh = base >> DIV_SHIFT;
    return (sh < 16'd2) ? 16'd2 : sh;
  endfunction

  // Highest pressed key wins.
  always_comb begin
    winner = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (key_q[i]) winner = 3'(i);
    end
  end

  assign terminal = (count == half - 16'd1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      key_q      <= 8'd0;
      tone_out   <= 1'b0;
      note_idx   <= 3'd0;
      note_valid <= 1'b0;
      busy       <= 1'b0;
      half       <= 16'd0;
      count      <= 16'd0;
      gap_cnt    <= 32'd0;
      pend       <= 1'b0;
    end else begin
      key_q <= key;
      if (!enable) begin
        state      <= IDLE;
        tone_out   <= 1'b0;
        note_valid <= 1'b0;
        busy       <= 1'b0;
        count      <= 16'd0;
        gap_cnt    <= 32'd0;
        pend       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (key_q != 8'd0) begin
              state      <= LOAD;
              note_valid <= 1'b1;
              busy       <= 1'b1;
            end
          end
          LOAD: begin
            note_idx <= winner;
            half     <= half_of(winner);
            count    <= 16'd0;
            state    <= PLAY;
          end
          PLAY: begin
            count <= terminal ? 16'd0 : count + 16'd1;
            // On the exit cycle a terminal count may only end a high half, never start one.
            if (key_q == 8'd0 || winner != note_idx) begin
              state <= RELEASE;
              pend  <= (key_q != 8'd0);
              if (terminal && tone_out) tone_out <= 1'b0;
            end else if (terminal) begin
              tone_out <= ~tone_out;
            end
          end
          RELEASE: begin
            if (!tone_out || terminal) begin
              tone_out   <= 1'b0;
              count      <= 16'd0;
              note_valid <= 1'b0;
              if (pend) begin
                state   <= GAP;
                gap_cnt <= 32'd0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              count <= count + 16'd1;
            end
          end
          GAP: begin
            if (gap_cnt == 32'(GAP_CYC - 1)) begin
              pend <= 1'b0;
              if (key_q != 8'd0) begin
                state      <= LOAD;
                note_valid <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              gap_cnt <= gap_cnt + 32'd1;
            end
          end
          default: begin
            state      <= IDLE;
            tone_out   <= 1'b0;
            note_valid <= 1'b0;
            busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/tone_key_scheduler.md
Name: tone_key_scheduler

Overview:
- Arbitrates eight note keys onto one shared programmable tone divider. Selects the winning key, loads its half-period count and generates a square-wave tone.
- Sits between the keypad input stage and the audio output pin, replacing one fixed divider per note.
- Note changes and releases are sequenced so the output never produces a truncated high pulse.

Parameters:
- DIV_SHIFT, 0: right-shift applied to every table half-period. Used in simulation to shorten periods. Any shifted value below 2 is clamped to 2.
- GAP_CYC, 1000: number of silent cycles inserted between two different notes. Must be at least 1.

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  synchronous active-low reset
- key  in  8  note request lines, active high. Bit 0 = C5 ... bit 7 = C6.
- enable  in  1  global play enable; low forces silence
- tone_out  out  1  square-wave tone
- note_idx  out  3  index of the note currently loaded
- note_valid  out  1  high while in LOAD, PLAY or RELEASE
- busy  out  1  high in any state other than IDLE

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst).
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - tone_out=0, note_idx=0, note_valid=0, busy=0.
  - Counters and key_q are cleared.
  - Reset asserted mid-note takes effect at that same edge, with no release sequence.
- Input register: key is registered into key_q every cycle. All decisions use key_q.
- Winner selection: the highest set index of key_q (highest pitch wins). Combinational from key_q.
- Half-period table (before shift):
  - Indices 0..3: 47778, 42566, 37921, 35793
  - Indices 4..7: 31888, 28409, 25310, 23889
  - half = max(table[idx] >> DIV_SHIFT, 2). Widths are 16 bits.
- FSM states: IDLE, LOAD, PLAY, RELEASE, GAP.
- IDLE:
  - tone_out=0.
  - Goes to LOAD when enable=1 and key_q != 0.
- LOAD (1 cycle):
  - note_idx <= winner; half register <= table value; count <= 0.
  - Next state is PLAY.
- PLAY:
  - count increments each cycle.
  - When count == half-1: count <= 0 and tone_out toggles.
  - Period = 2*half cycles. The first rising edge occurs half cycles after LOAD.
- Exits from PLAY, in priority order:
  1. enable=0: go to IDLE next cycle and force tone_out=0. Abrupt mute is allowed.
  2. key_q == 0: go to RELEASE.
  3. winner != note_idx: go to RELEASE with a pending-change flag set.
- RELEASE:
  - If tone_out=0, leave immediately.
  - Otherwise keep counting until the toggle to 0, then leave.
  - Destination is GAP if the pending-change flag is set, otherwise IDLE.
  - Key changes during RELEASE never shorten the high half.
- GAP:
  - tone_out=0 for GAP_CYC cycles.
  - Then goes to LOAD if key_q != 0 and enable=1, otherwise IDLE. The flag is cleared.
- Simultaneous events:
  - enable=0 overrides everything except reset.
  - A new higher key arriving in the same cycle as the old key's release takes the change path (via GAP).
- tone_out is registered and glitch-free. It changes only in PLAY/RELEASE at a terminal count, or to 0 on enable=0 or reset.

Test Plan:
1. Reset and idle: DIV_SHIFT=8, rst=0 for 3 cycles, key=8'h01 held during reset → tone_out=0, busy=0, note_idx=0. After release of rst, LOAD occurs 2 cycles later.
2. Single note: key=8'h01, enable=1 → note_idx=0 and half=186. Measure tone_out high=186, low=186, period 372 cycles. Repeat with key=8'h80 → half=93, period 186.
3. Priority: key=8'h11 → note_idx=4 and half=124 (31888>>8). No output toggles are referenced to index 0.
4. Note change: GAP_CYC=10; playing idx 0, switch to key=8'h20 while tone_out=1 → the high phase completes its full 186 cycles, then 10 cycles low (GAP), then LOAD with note_idx=5 and half=110.
5. Release: key drops to 0 mid-high-phase → tone_out finishes the high half, then IDLE, busy=0. Release during the low phase → IDLE on the next cycle.
6. Enable/reset mid-note: enable=0 while tone_out=1 → tone_out=0 within 1 cycle, IDLE. rst=0 mid-PLAY → all outputs 0 at that edge.
